// File: rtl/train_scheduler.sv
// train_scheduler: EPOCHS training passes then one test pass over SIZE samples; optional `LR_DECAY_EN halves oLR after each training pass.
// Latency: valids are registered and rise one cycle after the issue decision; one idle cycle separates samples.
// Backpressure: each channel holds valid until its own ready; no new sample starts while MAXINF samples are in flight.
module train_scheduler #(
    parameter int SIZE   = 3,
    parameter int EPOCHS = 2,
    parameter int LR     = 64,
    parameter int MAXINF = 4
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    input  logic                         iStart,
    output logic                         oBusy,
    output logic                         oDone,
    output logic                         oMode,
    output logic [7:0]                   oLR,
    output logic [$clog2(SIZE)-1:0]      oAddr,
    output logic [$clog2(EPOCHS+1)-1:0]  oEpoch,
    output logic                         oValid_BM_Input,
    input  logic                         iReady_BM_Input,
    output logic                         oValid_BM_Teacher,
    input  logic                         iReady_BM_Teacher,
    input  logic                         iValid_AM_Output,
    output logic                         oReady_AM_Output,
    output logic [$clog2(SIZE+1)-1:0]    oCount_Output
);
    localparam int AW = $clog2(SIZE);
    localparam int EW = $clog2(EPOCHS+1);
    localparam int CW = $clog2(SIZE+1);
    localparam int FW = $clog2(MAXINF+1);
    localparam logic [AW-1:0] ADDR_LAST  = AW'(SIZE-1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(SIZE);
    localparam logic [FW-1:0] INF_MAX    = FW'(MAXINF);
    localparam logic [EW-1:0] EPOCH_LAST = EW'(EPOCHS-1);
    localparam logic [7:0]    LR_INIT    = 8'(LR);

    typedef enum logic [2:0] {IDLE, TRAIN, TDRAIN, TEST, XDRAIN, DONE} state_t;

    state_t         r_state;
    logic           r_busy, r_done, r_mode, r_rdy;
    logic           r_vld_in, r_vld_tch, r_active;
    logic [AW-1:0]  r_addr;
    logic [EW-1:0]  r_epoch;
    logic [CW-1:0]  r_cnt;
    logic [FW-1:0]  r_inflight;

    logic w_issuing, w_out_hs, w_sample_done, w_launch, w_pass_full;

    assign w_issuing     = (r_state == TRAIN) || (r_state == TEST);
    assign w_out_hs      = iValid_AM_Output && r_rdy;
    // A sample is complete once every channel it raised has handshaked, in any order.
    assign w_sample_done = r_active && (!r_vld_in || iReady_BM_Input)
                                    && (!r_vld_tch || iReady_BM_Teacher);
    assign w_launch      = w_issuing && !r_active && (r_inflight < INF_MAX);
    assign w_pass_full   = (r_cnt == CNT_FULL);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mode     <= 1'b0;
            r_rdy      <= 1'b0;
            r_vld_in   <= 1'b0;
            r_vld_tch  <= 1'b0;
            r_active   <= 1'b0;
            r_addr     <= '0;
            r_epoch    <= '0;
            r_cnt      <= '0;
            r_inflight <= '0;
        end else begin
            if (r_vld_in && iReady_BM_Input)   r_vld_in  <= 1'b0;
            if (r_vld_tch && iReady_BM_Teacher) r_vld_tch <= 1'b0;
            if (w_launch) begin
                r_active  <= 1'b1;
                r_vld_in  <= 1'b1;
                r_vld_tch <= (r_state == TRAIN);
            end
            if (w_sample_done) r_active <= 1'b0;

            case ({w_sample_done, w_out_hs})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   if (r_inflight != '0) r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            if (w_out_hs) r_cnt <= r_cnt + 1'b1;

            case (r_state)
                IDLE: if (iStart) begin
                    r_state <= TRAIN;
                    r_busy  <= 1'b1;
                    r_mode  <= 1'b1;
                    r_rdy   <= 1'b1;
                    r_addr  <= '0;
                    r_epoch <= '0;
                    r_cnt   <= '0;
                end
                TRAIN, TEST: if (w_sample_done) begin
                    if (r_addr == ADDR_LAST)
                        r_state <= (r_state == TRAIN) ? TDRAIN : XDRAIN;
                    else
                        r_addr <= r_addr + 1'b1;
                end
                // Full count implies nothing in flight, so the mode switch is safe here.
                TDRAIN: if (w_pass_full) begin
                    r_epoch <= r_epoch + 1'b1;
                    r_addr  <= '0;
                    r_cnt   <= '0;
                    if (r_epoch < EPOCH_LAST) begin
                        r_state <= TRAIN;
                    end else begin
                        r_state <= TEST;
                        r_mode  <= 1'b0;
                    end
                end
                XDRAIN: if (w_pass_full) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                    r_rdy   <= 1'b0;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef LR_DECAY_EN
    logic [7:0] r_lr;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_lr <= LR_INIT;
        end else if (r_state == IDLE && iStart) begin
            r_lr <= LR_INIT;
        end else if (r_state == TDRAIN && w_pass_full) begin
            r_lr <= (r_lr[7:1] == 7'd0) ? 8'd1 : {1'b0, r_lr[7:1]};
        end
    end

    assign oLR = r_lr;
`else
    assign oLR = LR_INIT;
`endif

    assign oBusy             = r_busy;
    assign oDone             = r_done;
    assign oMode             = r_mode;
    assign oAddr             = r_addr;
    assign oEpoch            = r_epoch;
    assign oValid_BM_Input   = r_vld_in;
    assign oValid_BM_Teacher = r_vld_tch;
    assign oReady_AM_Output  = r_rdy;
    assign oCount_Output     = r_cnt;

endmodule

// File: tb/tb_train_scheduler.sv
// Bench for train_scheduler: table of run configurations plus hand-written stall, in-flight-limit and reset sequences.
// A scoreboard queue holds the expected {addr, mode, lr, epoch} of every sample, popped as each sample completes.
module tb_train_scheduler;
    localparam int SIZE   = 3;
    localparam int EPOCHS = 2;
    localparam int LR     = 64;
    localparam int MAXINF = 2;
    localparam int AW = $clog2(SIZE);
    localparam int EW = $clog2(EPOCHS+1);
    localparam int CW = $clog2(SIZE+1);

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic          iStart = 1'b0;
    logic          oBusy, oDone, oMode;
    logic [7:0]    oLR;
    logic [AW-1:0] oAddr;
    logic [EW-1:0] oEpoch;
    logic          oValid_BM_Input, oValid_BM_Teacher, oReady_AM_Output;
    logic          iReady_BM_Input = 1'b0;
    logic          iReady_BM_Teacher = 1'b0;
    logic          iValid_AM_Output = 1'b0;
    logic [CW-1:0] oCount_Output;

    always #5 iCLK = ~iCLK;

    train_scheduler #(.SIZE(SIZE), .EPOCHS(EPOCHS), .LR(LR), .MAXINF(MAXINF)) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart),
        .oBusy(oBusy), .oDone(oDone), .oMode(oMode), .oLR(oLR),
        .oAddr(oAddr), .oEpoch(oEpoch),
        .oValid_BM_Input(oValid_BM_Input), .iReady_BM_Input(iReady_BM_Input),
        .oValid_BM_Teacher(oValid_BM_Teacher), .iReady_BM_Teacher(iReady_BM_Teacher),
        .iValid_AM_Output(iValid_AM_Output), .oReady_AM_Output(oReady_AM_Output),
        .oCount_Output(oCount_Output)
    );

    typedef struct { int addr; int mode; int lr; int epoch; } exp_t;
    typedef struct { int p_in; int p_tch; int delay; int exp_samples; int exp_epoch; int exp_max; } vec_t;

    exp_t sb_q[$];
    int   out_due[$];
    int   n_vec = 0, n_err = 0;
    int   cyc = 0, inflight_m = 0, max_inf = 0, samples = 0, outs = 0, done_cnt = 0;
    int   viol = 0, tch_test = 0, mode_viol = 0, cnt_at_done = -1, epoch_at_done = -1;
    int   p_in = 0, p_tch = 0, out_delay = 2, tch_block = 0;
    bit   got_in = 0, got_tch = 0, prev_any = 0, prev_mode = 0, out_hold = 0, start_req = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int lr_for_pass(input int p);
        int v;
        v = LR;
`ifdef LR_DECAY_EN
        for (int k = 0; k < p; k++) v = ((v >> 1) == 0) ? 1 : (v >> 1);
`endif
        return v;
    endfunction

    task automatic reset_model();
        sb_q.delete();
        out_due.delete();
        inflight_m = 0; got_in = 0; got_tch = 0; prev_any = 0; prev_mode = 0;
        tch_block = 0; out_hold = 0; start_req = 0;
    endtask

    // One clock: observe outputs, drive next inputs, update the model with the handshakes they make.
    task automatic tick();
        exp_t e;
        @(negedge iCLK);
        cyc++;
        if ((oValid_BM_Input || oValid_BM_Teacher) && !prev_any && inflight_m >= MAXINF) viol++;
        prev_any = oValid_BM_Input || oValid_BM_Teacher;
        if (!oMode && oValid_BM_Teacher) tch_test++;
        if (oMode != prev_mode && inflight_m != 0) mode_viol++;
        prev_mode = oMode;
        if (oDone) begin
            done_cnt++;
            cnt_at_done = int'(oCount_Output);
            epoch_at_done = int'(oEpoch);
        end
        iStart = start_req;
        start_req = 0;
        iReady_BM_Input = (int'($urandom_range(0, 99)) >= p_in);
        if (tch_block > 0 && oValid_BM_Teacher) begin
            iReady_BM_Teacher = 1'b0;
            tch_block--;
        end else begin
            iReady_BM_Teacher = (int'($urandom_range(0, 99)) >= p_tch);
        end
        iValid_AM_Output = 1'b0;
        if (!out_hold && out_due.size() > 0)
            if (out_due[0] <= cyc) iValid_AM_Output = 1'b1;
        if (oValid_BM_Input && iReady_BM_Input) got_in = 1;
        if (oValid_BM_Teacher && iReady_BM_Teacher) got_tch = 1;
        if (got_in && (got_tch || !oMode)) begin
            got_in = 0;
            got_tch = 0;
            samples++;
            inflight_m++;
            if (inflight_m > max_inf) max_inf = inflight_m;
            out_due.push_back(cyc + out_delay);
            if (sb_q.size() == 0) begin
                check("sb_underflow", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                check("sample_addr", oAddr, e.addr);
                check("sample_mode", oMode, e.mode);
                check("sample_lr", oLR, e.lr);
                check("sample_epoch", oEpoch, e.epoch);
            end
        end
        if (iValid_AM_Output && oReady_AM_Output) begin
            void'(out_due.pop_front());
            outs++;
            if (inflight_m > 0) inflight_m--;
        end
    endtask

    task automatic start_run();
        exp_t e;
        samples = 0; outs = 0; done_cnt = 0; viol = 0; tch_test = 0; mode_viol = 0;
        max_inf = 0; cnt_at_done = -1; epoch_at_done = -1;
        for (int p = 0; p <= EPOCHS; p++)
            for (int a = 0; a < SIZE; a++) begin
                e.addr = a; e.mode = (p < EPOCHS) ? 1 : 0; e.lr = lr_for_pass(p); e.epoch = p;
                sb_q.push_back(e);
            end
        start_req = 1;
        tick();
    endtask

    task automatic finish_run(input int exp_samples, input int exp_epoch);
        int k;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            tick();
            k++;
        end
        check("run_timeout", done_cnt > 0, 1);
        repeat (3) tick();
        check("samples", samples, exp_samples);
        check("outputs", outs, exp_samples);
        check("done_pulses", done_cnt, 1);
        check("epoch_at_done", epoch_at_done, exp_epoch);
        check("count_at_done", cnt_at_done, SIZE);
        check("sb_left", sb_q.size(), 0);
        check("inflight_limit", viol, 0);
        check("teacher_in_test", tch_test, 0);
        check("mode_change_busy", mode_viol, 0);
        check("max_inflight_bound", max_inf <= MAXINF, 1);
        check("busy_after_done", oBusy, 0);
        check("lr_after_done", oLR, lr_for_pass(EPOCHS));
    endtask

    task automatic check_reset();
        check("rst_valid_in", oValid_BM_Input, 0);
        check("rst_valid_tch", oValid_BM_Teacher, 0);
        check("rst_ready_out", oReady_AM_Output, 0);
        check("rst_busy", oBusy, 0);
        check("rst_done", oDone, 0);
        check("rst_mode", oMode, 0);
        check("rst_lr", oLR, LR);
        check("rst_addr", oAddr, 0);
        check("rst_epoch", oEpoch, 0);
        check("rst_count", oCount_Output, 0);
    endtask

    vec_t tbl[6];

    initial begin
        int k;
        tbl[0] = '{0, 0, 2, (EPOCHS+1)*SIZE, EPOCHS, 0};
        tbl[1] = '{30, 0, 2, (EPOCHS+1)*SIZE, EPOCHS, 0};
        tbl[2] = '{0, 50, 5, (EPOCHS+1)*SIZE, EPOCHS, 0};
        tbl[3] = '{40, 40, 8, (EPOCHS+1)*SIZE, EPOCHS, 0};
        tbl[4] = '{0, 0, 20, (EPOCHS+1)*SIZE, EPOCHS, MAXINF};
        tbl[5] = '{20, 60, 1, (EPOCHS+1)*SIZE, EPOCHS, 0};
        reset_model();

        repeat (3) @(negedge iCLK);
        check_reset();
        iRST = 1'b1;
        repeat (4) tick();
        check("idle_without_start", oBusy, 0);

        for (int i = 0; i < 6; i++) begin
            p_in = tbl[i].p_in; p_tch = tbl[i].p_tch; out_delay = tbl[i].delay;
            start_run();
            finish_run(tbl[i].exp_samples, tbl[i].exp_epoch);
            if (tbl[i].exp_max > 0) check("max_inflight_sat", max_inf, tbl[i].exp_max);
        end

        // Teacher stalls three cycles after the input channel has already handshaked.
        p_in = 0; p_tch = 0; out_delay = 2; tch_block = 3;
        start_run();
        k = 0;
        while (!(oValid_BM_Input && oValid_BM_Teacher) && k < 50) begin tick(); k++; end
        check("stall_first_valid", oValid_BM_Input && oValid_BM_Teacher, 1);
        check("stall_addr0", oAddr, 0);
        for (int j = 0; j < 3; j++) begin
            tick();
            check("stall_addr_hold", oAddr, 0);
            check("stall_in_dropped", oValid_BM_Input, 0);
            check("stall_tch_held", oValid_BM_Teacher, 1);
        end
        k = 0;
        while (!oValid_BM_Input && k < 50) begin tick(); k++; end
        check("stall_addr_advance", oAddr, 1);
        finish_run((EPOCHS+1)*SIZE, EPOCHS);

        // Outputs withheld: issue must stop at the in-flight limit until one output returns.
        out_hold = 1;
        start_run();
        repeat (30) tick();
        check("hold_issued", samples, MAXINF);
        check("hold_valids_low", oValid_BM_Input || oValid_BM_Teacher, 0);
        out_hold = 0;
        k = 0;
        while (!oValid_BM_Input && k < 60) begin tick(); k++; end
        check("release_needs_output", outs >= 1, 1);
        finish_run((EPOCHS+1)*SIZE, EPOCHS);

        // iStart while busy is ignored; reset mid-TEST returns everything to idle immediately.
        out_delay = 20;
        start_run();
        k = 0;
        while (oEpoch != 1 && k < 500) begin tick(); k++; end
        check("reach_epoch1", oEpoch, 1);
        start_req = 1;
        tick();
        tick();
        check("busy_start_busy", oBusy, 1);
        check("busy_start_epoch", oEpoch, 1);
        k = 0;
        while (!(!oMode && oBusy && inflight_m >= 1) && k < 500) begin tick(); k++; end
        check("reach_test_inflight", !oMode && oBusy && inflight_m >= 1, 1);
        #2;
        iRST = 1'b0;
        #1;
        check_reset();
        reset_model();
        repeat (2) tick();
        iRST = 1'b1;
        repeat (6) tick();
        check("post_reset_idle", oBusy, 0);
        check("post_reset_no_valid", oValid_BM_Input || oValid_BM_Teacher, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/train_scheduler.md
TRAIN_SCHEDULER -- requirements
Module: train_scheduler

Interface
REQ-001 Parameters SHALL be: SIZE, 3, samples per pass; EPOCHS, 2, training passes before test; LR, 64, initial learning rate (8-bit); MAXINF, 4, max samples in flight in the network.
REQ-002 Ports SHALL be: iCLK in 1 clock; iRST in 1 asynchronous active-low reset; iStart in 1 start pulse; oBusy out 1 run in progress; oDone out 1 one-cycle completion pulse.
REQ-003 Mode/LR ports SHALL be: oMode out 1 network mode (1=TRAIN, 0=TEST); oLR out 8 learning rate to network.
REQ-004 Sample ports SHALL be: oAddr out $clog2(SIZE) sample index to input/teacher memories; oEpoch out $clog2(EPOCHS+1) completed training passes.
REQ-005 Stream ports SHALL be: oValid_BM_Input out 1; iReady_BM_Input in 1; oValid_BM_Teacher out 1; iReady_BM_Teacher in 1; iValid_AM_Output in 1; oReady_AM_Output out 1.
REQ-006 oCount_Output out $clog2(SIZE+1) SHALL report outputs received in the current pass.

Function
REQ-007 FSM states SHALL be IDLE, TRAIN, TDRAIN, TEST, XDRAIN, DONE.
REQ-008 IDLE->TRAIN on iStart=1; iStart SHALL be ignored in every other state.
REQ-009 TRAIN: issue samples 0..SIZE-1 at oAddr; oValid_BM_Input and oValid_BM_Teacher asserted together for each sample.
REQ-010 Each channel's valid SHALL deassert after its own handshake; oAddr advances only when both channels of the current sample have handshaked (same or different cycles).
REQ-011 TEST: issue samples 0..SIZE-1 on the input channel only; oValid_BM_Teacher SHALL be 0.
REQ-012 In-flight count = samples fully issued minus outputs received; new sample valids SHALL NOT assert while in-flight == MAXINF.
REQ-013 Simultaneous issue and output receipt SHALL leave in-flight unchanged.
REQ-014 oReady_AM_Output SHALL be 1 in TRAIN, TDRAIN, TEST, XDRAIN, else 0; each handshake increments oCount_Output.
REQ-015 After SIZE samples issued: TRAIN->TDRAIN, TEST->XDRAIN; no valids asserted in drain states.
REQ-016 TDRAIN exits when oCount_Output == SIZE: oEpoch increments; to TRAIN if oEpoch+1 < EPOCHS, else TEST; oAddr, oCount_Output cleared.
REQ-017 XDRAIN->DONE when oCount_Output == SIZE; DONE->IDLE after one cycle, oDone=1 during DONE.
REQ-018 oMode SHALL be 1 in TRAIN/TDRAIN, 0 otherwise; oMode changes only with in-flight == 0.
REQ-019 oBusy SHALL be 1 in all states except IDLE.
REQ-020 oAddr wraps to 0 at the start of every pass, never past SIZE-1.

Reset
REQ-021 iRST=0 SHALL asynchronously force IDLE, mid-operation included.
REQ-022 Reset values: all valids 0, oReady_AM_Output 0, oBusy 0, oDone 0, oMode 0, oLR = LR, oAddr 0, oEpoch 0, oCount_Output 0, in-flight 0.
REQ-023 After reset release, no action until a fresh iStart.

Configuration
REQ-024 With LR_DECAY_EN defined, on each TDRAIN exit oLR SHALL become max(oLR>>1, 1), and SHALL reload LR on iStart.
REQ-025 Without LR_DECAY_EN, oLR SHALL equal LR constantly.

Verification
REQ-026 SIZE=3, EPOCHS=2, all readies 1, outputs returned 2 cycles after input -> 3 TRAIN passes? no: 2 TRAIN passes, 1 TEST pass, oAddr 0,1,2 each, oDone pulse once, oEpoch=2.
REQ-027 iReady_BM_Teacher held 0 for 3 cycles while iReady_BM_Input=1 -> oAddr holds, input valid drops after handshake, advances only after teacher handshake.
REQ-028 MAXINF=2, outputs withheld -> exactly 2 samples issued, valids stay 0 until an output handshake.
REQ-029 iRST=0 during TEST with 1 sample in flight -> immediate IDLE, all outputs at reset values; iStart during busy -> no effect.
REQ-030 LR_DECAY_EN, LR=64, EPOCHS=3 -> oLR 64, 32, 16 in successive TRAIN passes, 8 in TEST; undefined -> 64 throughout.
